// File: rtl/is_tx_msg_arbiter.sv
// Arbitrates the error and result message requesters onto the shared ROM and UART TX.
// Optional CR/LF trailer enabled by defining IS_TX_CRLF_EN.
module is_tx_msg_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MEM_WIDTH = 6,
    parameter int RES_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 err_req_i,
    input  logic [MEM_WIDTH-1:0] err_a0_i,
    input  logic [MEM_WIDTH-1:0] err_a1_i,
    input  logic                 res_req_i,
    input  logic [MEM_WIDTH-1:0] res_a0_i,
    input  logic [MEM_WIDTH-1:0] res_a1_i,
    input  logic [RES_W-1:0]     res_val_i,
    output logic                 err_done_o,
    output logic                 res_done_o,
    output logic                 busy_o,
    output logic [MEM_WIDTH-1:0] addr_o,
    input  logic [DATA_W-1:0]    data_i,
    input  logic                 tx_rdy_r_i,
    output logic                 tx_rdy_t_o,
    output logic [DATA_W-1:0]    tx_data_t_o,
    output logic [2:0]           state_o
);

    localparam int NDIG  = RES_W / 4;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ROM_RD, S_ROM_TX, S_HEX_TX, S_CR_TX, S_LF_TX, S_DONE
    } state_t;

`ifdef IS_TX_CRLF_EN
    localparam state_t S_TAIL = S_CR_TX;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t               state, state_d;
    logic                 sel_res;
    logic [MEM_WIDTH-1:0] a1_q, addr_q;
    logic [RES_W-1:0]     res_sh;
    logic [CNT_W-1:0]     dig_q;
    logic                 stb_q;
    logic [DATA_W-1:0]    data_q;

    logic                 can_tx, grant, grant_res, send, addr_inc, hex_step;
    logic [MEM_WIDTH-1:0] load_a0, load_a1;
    logic [DATA_W-1:0]    send_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Handshake: a byte is launched only when the UART reports idle and no
    // strobe was issued in the previous cycle (the UART needs a cycle to drop ready).
    assign can_tx = tx_rdy_r_i && !stb_q;

    always_comb begin
        state_d   = state;
        grant     = 1'b0;
        grant_res = 1'b0;
        load_a0   = '0;
        load_a1   = '0;
        send      = 1'b0;
        send_byte = '0;
        addr_inc  = 1'b0;
        hex_step  = 1'b0;
        case (state)
            S_IDLE: begin
                if (err_req_i) begin
                    grant   = 1'b1;
                    load_a0 = err_a0_i;
                    load_a1 = err_a1_i;
                    state_d = (err_a1_i < err_a0_i) ? S_TAIL : S_ROM_RD;
                end else if (res_req_i) begin
                    grant     = 1'b1;
                    grant_res = 1'b1;
                    load_a0   = res_a0_i;
                    load_a1   = res_a1_i;
                    state_d   = (res_a1_i < res_a0_i) ? S_HEX_TX : S_ROM_RD;
                end
            end
            S_ROM_RD: state_d = S_ROM_TX;
            S_ROM_TX: begin
                if (can_tx) begin
                    send      = 1'b1;
                    send_byte = data_i;
                    // Stop on equality so a segment ending at the top address never wraps.
                    if (addr_q == a1_q) begin
                        state_d = sel_res ? S_HEX_TX : S_TAIL;
                    end else begin
                        addr_inc = 1'b1;
                        state_d  = S_ROM_RD;
                    end
                end
            end
            S_HEX_TX: begin
                if (can_tx) begin
                    send      = 1'b1;
                    send_byte = DATA_W'(hex_char(res_sh[RES_W-1 -: 4]));
                    hex_step  = 1'b1;
                    if (dig_q == CNT_W'(NDIG - 1)) state_d = S_TAIL;
                end
            end
`ifdef IS_TX_CRLF_EN
            S_CR_TX: begin
                if (can_tx) begin
                    send      = 1'b1;
                    send_byte = DATA_W'(8'h0D);
                    state_d   = S_LF_TX;
                end
            end
            S_LF_TX: begin
                if (can_tx) begin
                    send      = 1'b1;
                    send_byte = DATA_W'(8'h0A);
                    state_d   = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= S_IDLE;
            sel_res <= 1'b0;
            a1_q    <= '0;
            addr_q  <= '0;
            res_sh  <= '0;
            dig_q   <= '0;
            stb_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state <= state_d;
            stb_q <= send;
            if (send) data_q <= send_byte;
            if (grant) begin
                sel_res <= grant_res;
                a1_q    <= load_a1;
                addr_q  <= load_a0;
                dig_q   <= '0;
                res_sh  <= grant_res ? res_val_i : '0;
            end
            if (addr_inc) addr_q <= addr_q + 1'b1;
            // Shift the next nibble into the top position after each digit.
            if (hex_step) begin
                res_sh <= res_sh << 4;
                dig_q  <= dig_q + 1'b1;
            end
        end
    end

    assign err_done_o  = (state == S_DONE) && !sel_res;
    assign res_done_o  = (state == S_DONE) &&  sel_res;
    assign busy_o      = (state != S_IDLE);
    assign addr_o      = addr_q;
    assign tx_rdy_t_o  = stb_q;
    assign tx_data_t_o = data_q;
    assign state_o     = state;

endmodule

// File: tb/tb_is_tx_msg_arbiter.sv
// Directed bench for is_tx_msg_arbiter: ROM and UART models, byte scoreboard, done tracking.
module tb_is_tx_msg_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        err_req_i = 1'b0, res_req_i = 1'b0;
    logic [5:0]  err_a0_i = '0, err_a1_i = '0, res_a0_i = '0, res_a1_i = '0;
    logic [15:0] res_val_i = '0;
    logic        err_done_o, res_done_o, busy_o, tx_rdy_t_o, tx_rdy_r_i;
    logic [5:0]  addr_o;
    logic [7:0]  data_i = '0, tx_data_t_o;
    logic [2:0]  state_o;

    is_tx_msg_arbiter dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .err_req_i(err_req_i), .err_a0_i(err_a0_i), .err_a1_i(err_a1_i),
        .res_req_i(res_req_i), .res_a0_i(res_a0_i), .res_a1_i(res_a1_i),
        .res_val_i(res_val_i),
        .err_done_o(err_done_o), .res_done_o(res_done_o), .busy_o(busy_o),
        .addr_o(addr_o), .data_i(data_i),
        .tx_rdy_r_i(tx_rdy_r_i), .tx_rdy_t_o(tx_rdy_t_o), .tx_data_t_o(tx_data_t_o),
        .state_o(state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rom [64];
    int  stb_cnt = 0, err_done_cnt = 0, res_done_cnt = 0;
    logic prev_stb = 1'b0, prev_err_done = 1'b0, prev_res_done = 1'b0;
    logic rdy_at_edge = 1'b0;
    logic hold_low = 1'b0;
    int  busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ROM model: one cycle read latency
    always @(posedge clk_i) data_i <= rom[addr_o];

    // UART model: busy two cycles after each strobe, optionally forced not ready
    always @(posedge clk_i) begin
        rdy_at_edge <= tx_rdy_r_i;
        if (!rstn_i)          busy_cnt <= 0;
        else if (tx_rdy_t_o)  busy_cnt <= 2;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_rdy_r_i = (busy_cnt == 0) && !hold_low;

    // scoreboard / protocol monitor
    always @(negedge clk_i) begin
        if (tx_rdy_t_o) begin
            check("no_back_to_back", {31'b0, prev_stb}, 0);
            check("rdy_at_launch", {31'b0, rdy_at_edge}, 1);
            if (exp_q.size() == 0) check("unexpected_byte", {24'b0, tx_data_t_o}, 32'hFFFF_FFFF);
            else                   check("tx_byte", {24'b0, tx_data_t_o}, {24'b0, exp_q.pop_front()});
            stb_cnt++;
        end
        if (err_done_o) begin
            check("err_done_width", {31'b0, prev_err_done}, 0);
            err_done_cnt++;
        end
        if (res_done_o) begin
            check("res_done_width", {31'b0, prev_res_done}, 0);
            res_done_cnt++;
        end
        prev_stb      = tx_rdy_t_o;
        prev_err_done = err_done_o;
        prev_res_done = res_done_o;
    end

    // driver tasks
    task automatic push_crlf();
`ifdef IS_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic req_err(input logic [5:0] a0, input logic [5:0] a1);
        err_a0_i = a0; err_a1_i = a1; err_req_i = 1'b1;
    endtask

    task automatic req_res(input logic [5:0] a0, input logic [5:0] a1, input logic [15:0] v);
        res_a0_i = a0; res_a1_i = a1; res_val_i = v; res_req_i = 1'b1;
    endtask

    task automatic run_until_idle(input int budget, input bit ordered);
        int  n = 0;
        bit  fin = 1'b0;
        while (n < budget && !fin) begin
            @(negedge clk_i);
            n++;
            if (res_done_o && ordered) check("err_before_res", {31'b0, err_req_i}, 0);
            if (err_done_o) err_req_i = 1'b0;
            if (res_done_o) res_req_i = 1'b0;
            if (!err_req_i && !res_req_i && !busy_o) fin = 1'b1;
        end
        check("finish_in_budget", {31'b0, fin}, 1);
        check("exp_drained", exp_q.size(), 0);
    endtask

    task automatic wait_stb(input int target, input int budget);
        int n = 0;
        while (n < budget && stb_cnt < target) begin
            @(negedge clk_i);
            n++;
        end
        check("stb_reached", {31'b0, (stb_cnt >= target)}, 1);
    endtask

    int e0, r0, s0;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 8'h40 + 8'(i);
        rom[3] = 8'h45; rom[4] = 8'h52; rom[5] = 8'h52;
        rom[8] = 8'h3D; rom[9] = 8'h20;

        repeat (3) @(negedge clk_i);
        check("rst_busy", {31'b0, busy_o}, 0);
        check("rst_stb", {31'b0, tx_rdy_t_o}, 0);
        check("rst_data", {24'b0, tx_data_t_o}, 0);
        check("rst_addr", {26'b0, addr_o}, 0);
        check("rst_done", {30'b0, err_done_o, res_done_o}, 0);
        check("rst_state", {29'b0, state_o}, 0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // 1: error message "ERR"
        e0 = err_done_cnt;
        exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52); push_crlf();
        req_err(6'd3, 6'd5);
        @(negedge clk_i);
        check("busy_after_grant", {31'b0, busy_o}, 1);
        run_until_idle(200, 1'b0);
        check("t1_err_done", err_done_cnt - e0, 1);

        // 2: result "= " + 0A3F
        r0 = res_done_cnt;
        exp_q.push_back(8'h3D); exp_q.push_back(8'h20);
        exp_q.push_back(8'h30); exp_q.push_back(8'h41); exp_q.push_back(8'h33); exp_q.push_back(8'h46);
        push_crlf();
        req_res(6'd8, 6'd9, 16'h0A3F);
        run_until_idle(300, 1'b0);
        check("t2_res_done", res_done_cnt - r0, 1);

        // 3: simultaneous requests, error wins
        e0 = err_done_cnt; r0 = res_done_cnt;
        exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52); push_crlf();
        exp_q.push_back(8'h3D); exp_q.push_back(8'h20);
        exp_q.push_back(8'h43); exp_q.push_back(8'h30); exp_q.push_back(8'h44); exp_q.push_back(8'h39);
        push_crlf();
        req_err(6'd3, 6'd5);
        req_res(6'd8, 6'd9, 16'hC0D9);
        run_until_idle(600, 1'b1);
        check("t3_err_done", err_done_cnt - e0, 1);
        check("t3_res_done", res_done_cnt - r0, 1);

        // 4: transmitter stalls 20 cycles mid-message
        e0 = err_done_cnt;
        for (int i = 10; i <= 15; i++) exp_q.push_back(8'h40 + 8'(i));
        push_crlf();
        s0 = stb_cnt;
        req_err(6'd10, 6'd15);
        wait_stb(s0 + 2, 100);
        hold_low = 1'b1;
        @(negedge clk_i);
        s0 = stb_cnt;
        repeat (20) @(negedge clk_i);
        check("t4_no_stb_while_stalled", stb_cnt, s0);
        hold_low = 1'b0;
        run_until_idle(300, 1'b0);
        check("t4_err_done", err_done_cnt - e0, 1);

        // 5: empty segment a1 < a0
        e0 = err_done_cnt; s0 = stb_cnt;
        push_crlf();
        req_err(6'd5, 6'd3);
        run_until_idle(100, 1'b0);
        check("t5_err_done", err_done_cnt - e0, 1);
`ifdef IS_TX_CRLF_EN
        check("t5_stb_count", stb_cnt - s0, 2);
`else
        check("t5_stb_count", stb_cnt - s0, 0);
`endif

        // 7: single-byte segment a0 == a1
        e0 = err_done_cnt;
        exp_q.push_back(8'h4A); push_crlf();
        req_err(6'd10, 6'd10);
        run_until_idle(100, 1'b0);
        check("t7_err_done", err_done_cnt - e0, 1);

        // 8: segment ending at top ROM address, no wrap
        e0 = err_done_cnt;
        exp_q.push_back(8'h7E); exp_q.push_back(8'h7F); push_crlf();
        req_err(6'd62, 6'd63);
        run_until_idle(100, 1'b0);
        check("t8_err_done", err_done_cnt - e0, 1);
        check("t8_addr_top", {26'b0, addr_o}, 63);

        // 6: reset asserted during hex output
        r0 = res_done_cnt; s0 = stb_cnt;
        exp_q.push_back(8'h3D); exp_q.push_back(8'h20);
        exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33); exp_q.push_back(8'h34);
        push_crlf();
        req_res(6'd8, 6'd9, 16'h1234);
        wait_stb(s0 + 3, 100);
        @(negedge clk_i);
        rstn_i = 1'b0;
        res_req_i = 1'b0;
        @(negedge clk_i);
        check("t6_rst_busy", {31'b0, busy_o}, 0);
        check("t6_rst_stb", {31'b0, tx_rdy_t_o}, 0);
        check("t6_rst_data", {24'b0, tx_data_t_o}, 0);
        check("t6_rst_addr", {26'b0, addr_o}, 0);
        exp_q.delete();
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("t6_idle_after", {29'b0, state_o}, 0);
        check("t6_no_res_done", res_done_cnt - r0, 0);
        check("t6_no_more_bytes", {31'b0, busy_o}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
